// File: rtl/qpp_interleaver_if.sv
// Bundles the bit-serial input handshake and the aligned ck/ckp output stream of the QPP
// interleaver.
//   Input side : in_valid, in_start, in_length, in_bit (to DUT); in_ready, in_err (from DUT)
//   Output side: data_valid, ck, ckp, length (from DUT)
// The master modport is the feeder/consumer view, and the slave modport is the interleaver view.
interface qpp_interleaver_if;
  logic in_valid;
  logic in_start;
  logic in_length;
  logic in_bit;
  logic in_ready;
  logic in_err;
  logic data_valid;
  logic ck;
  logic ckp;
  logic length;

  modport master (
    output in_valid, in_start, in_length, in_bit,
    input  in_ready, in_err, data_valid, ck, ckp, length
  );

  modport slave (
    input  in_valid, in_start, in_length, in_bit,
    output in_ready, in_err, data_valid, ck, ckp, length
  );
endinterface

// File: rtl/qpp_interleaver.sv
// QPP interleaver feeding a turbo encoder.
// The block buffers one code block of serial bits into one of two ping-pong banks. It replays a
// full bank as two aligned streams:
//   ck  - the natural-order bit i
//   ckp - the bit at PI(i) = (F1*i + F2*i^2) mod K
// Each output block is contiguous. Output blocks are separated by an idle gap of at least MIN_GAP
// cycles.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - slave view of qpp_interleaver_if
//     in_valid/in_start/in_length/in_bit, with in_ready and an in_err pulse
//     data_valid/ck/ckp/length as the registered output stream
module qpp_interleaver #(
  parameter int unsigned K_LONG   = 6144,
  parameter int unsigned K_SHORT  = 1056,
  parameter int unsigned F1_LONG  = 263,
  parameter int unsigned F2_LONG  = 480,
  parameter int unsigned F1_SHORT = 17,
  parameter int unsigned F2_SHORT = 66,
  parameter int unsigned MIN_GAP  = 4,
  parameter int unsigned AW       = 13
) (
  input  logic              clk,
  input  logic              rst,
  qpp_interleaver_if.slave  bus
);

  localparam int unsigned GW = $clog2(MIN_GAP + 1);

  localparam logic [AW:0] KL  = (AW+1)'(K_LONG);
  localparam logic [AW:0] KS  = (AW+1)'(K_SHORT);
  // First address increment (F1+F2) and per-step increment growth (2*F2), both reduced mod K.
  localparam logic [AW:0] G0L = (AW+1)'((F1_LONG + F2_LONG) % K_LONG);
  localparam logic [AW:0] D2L = (AW+1)'((2 * F2_LONG) % K_LONG);
  localparam logic [AW:0] G0S = (AW+1)'((F1_SHORT + F2_SHORT) % K_SHORT);
  localparam logic [AW:0] D2S = (AW+1)'((2 * F2_SHORT) % K_SHORT);

  localparam logic [1:0] BankEmpty   = 2'd0;
  localparam logic [1:0] BankFilling = 2'd1;
  localparam logic [1:0] BankFull    = 2'd2;
  localparam logic [1:0] BankReading = 2'd3;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPrime  = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StGap    = 2'd3;

  // Operands are both below k, so one conditional subtract is enough to reduce the sum.
  function automatic logic [AW:0] mod_add(input logic [AW:0] a, input logic [AW:0] b,
                                          input logic [AW:0] k);
    logic [AW:0] s;
    s = a + b;
    return (s >= k) ? (s - k) : s;
  endfunction

  logic             mem_q [2][K_LONG];

  logic [1:0]       bank_st_q [2];
  logic [1:0]       bank_st_d [2];
  logic [1:0]       bank_len_q, bank_len_d;
  logic             wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             in_err_q, in_err_d;

  logic [1:0]       rd_st_q, rd_st_d;
  logic             rd_bank_q, rd_bank_d;
  logic [AW:0]      rd_addr_q, rd_addr_d;
  logic [AW:0]      pi_q, pi_d;
  logic [AW:0]      g_q, g_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ck_q, ck_d;
  logic             ckp_q, ckp_d;
  logic             length_q, length_d;

  logic             wr_en;
  logic [AW-1:0]    wr_mem_addr;
  logic             rd_en;
  logic [1:0]       wr_st;
  logic             in_ready;
  logic [AW:0]      k_wr, k_rd, g0_rd, d2_rd;

  assign wr_st    = bank_st_q[wr_bank_q];
  assign in_ready = (wr_st == BankEmpty) || (wr_st == BankFilling);
  assign k_wr     = bank_len_q[wr_bank_q] ? KL : KS;
  assign k_rd     = bank_len_q[rd_bank_q] ? KL : KS;
  assign g0_rd    = bank_len_q[rd_bank_q] ? G0L : G0S;
  assign d2_rd    = bank_len_q[rd_bank_q] ? D2L : D2S;

  always_comb begin
    bank_st_d   = bank_st_q;
    bank_len_d  = bank_len_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_en       = 1'b0;
    wr_mem_addr = wr_addr_q;
    in_err_d    = 1'b0;

    rd_st_d     = rd_st_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    pi_d        = pi_q;
    g_d         = g_q;
    gap_cnt_d   = gap_cnt_q;
    ck_d        = ck_q;
    ckp_d       = ckp_q;
    length_d    = length_q;
    rd_en       = 1'b0;

    // Write side. The writer and the reader never touch the same bank in one cycle. The writer
    // owns only EMPTY/FILLING banks, and the reader owns only FULL/READING banks.
    if (bus.in_valid && in_ready) begin
      if (bus.in_start) begin
        // A start bit during a fill throws away the partial block and restarts the bank.
        in_err_d              = (wr_st == BankFilling);
        bank_st_d[wr_bank_q]  = BankFilling;
        bank_len_d[wr_bank_q] = bus.in_length;
        wr_en                 = 1'b1;
        wr_mem_addr           = '0;
        wr_addr_d             = AW'(1);
      end else if (wr_st == BankEmpty) begin
        in_err_d = 1'b1;
      end else begin
        wr_en       = 1'b1;
        wr_mem_addr = wr_addr_q;
        if ({1'b0, wr_addr_q} == k_wr - 1'b1) begin
          bank_st_d[wr_bank_q] = BankFull;
          wr_bank_d            = ~wr_bank_q;
          wr_addr_d            = '0;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
    end

    // Read side. rd_addr_q/pi_q hold the address pair issued this cycle. That pair is one index
    // ahead of the bit currently presented on ck/ckp.
    case (rd_st_q)
      StIdle: begin
        rd_addr_d = '0;
        pi_d      = '0;
        g_d       = g0_rd;
        if (bank_st_q[rd_bank_q] == BankFull) begin
          rd_st_d = StPrime;
        end
      end
      StPrime: begin
        rd_en                = 1'b1;
        bank_st_d[rd_bank_q] = BankReading;
        length_d             = bank_len_q[rd_bank_q];
        rd_st_d              = StStream;
      end
      StStream: begin
        if (rd_addr_q == k_rd) begin
          // ck/ckp now show bit K-1, and no further read is issued.
          bank_st_d[rd_bank_q] = BankEmpty;
          rd_bank_d            = ~rd_bank_q;
          gap_cnt_d            = '0;
          rd_st_d              = StGap;
        end else begin
          rd_en = 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GW'(MIN_GAP - 1)) begin
          rd_st_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: rd_st_d = StIdle;
    endcase

    if (rd_en) begin
      ck_d      = mem_q[rd_bank_q][rd_addr_q[AW-1:0]];
      ckp_d     = mem_q[rd_bank_q][pi_q[AW-1:0]];
      rd_addr_d = rd_addr_q + 1'b1;
      pi_d      = mod_add(pi_q, g_q, k_rd);
      g_d       = mod_add(g_q, d2_rd, k_rd);
    end
  end

  // Bit storage is not reset. Buffered data is discarded through the bank states.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_mem_addr] <= bus.in_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st_q  <= '{BankEmpty, BankEmpty};
      bank_len_q <= '0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      in_err_q   <= 1'b0;
      rd_st_q    <= StIdle;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      pi_q       <= '0;
      g_q        <= '0;
      gap_cnt_q  <= '0;
      ck_q       <= 1'b0;
      ckp_q      <= 1'b0;
      length_q   <= 1'b0;
    end else begin
      bank_st_q  <= bank_st_d;
      bank_len_q <= bank_len_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      in_err_q   <= in_err_d;
      rd_st_q    <= rd_st_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      pi_q       <= pi_d;
      g_q        <= g_d;
      gap_cnt_q  <= gap_cnt_d;
      ck_q       <= ck_d;
      ckp_q      <= ckp_d;
      length_q   <= length_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.in_err     = in_err_q;
  assign bus.data_valid = (rd_st_q == StStream);
  assign bus.ck         = ck_q;
  assign bus.ckp        = ckp_q;
  assign bus.length     = length_q;

endmodule
